// File: rtl/fp_fcl_sched.sv
// Upstream sequencer for the fixed-point fully-connected PE array: buffers one
// activation vector, streams activation/weight pairs per output group, returns group results.
module fp_fcl_sched #(
  parameter int PARALLEL   = 8,
  parameter int MAX_IN     = 256,
  parameter int MAX_GROUPS = 64,
  parameter int ADDR_W     = 14
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_start_i,
  input  logic [$clog2(MAX_IN+1)-1:0]       cfg_in_len_i,
  input  logic [$clog2(MAX_GROUPS+1)-1:0]   cfg_num_groups_i,
  output logic                              busy_o,
  output logic                              done_o,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [7:0]                        in_data_i,
  output logic                              w_ren_o,
  output logic [ADDR_W-1:0]                 w_addr_o,
  input  logic [PARALLEL*8-1:0]             w_rdata_i,
  output logic [7:0]                        pe_input_o,
  output logic [PARALLEL*8-1:0]             pe_w_o,
  output logic                              pe_clr_n_o,
  input  logic [PARALLEL*8-1:0]             pe_out_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [PARALLEL*8-1:0]             out_data_o,
  output logic [$clog2(MAX_GROUPS)-1:0]     out_group_o
);

  localparam int LEN_W  = $clog2(MAX_IN+1);
  localparam int GRP_W  = $clog2(MAX_GROUPS+1);
  localparam int GIDX_W = $clog2(MAX_GROUPS);
  localparam int IDX_W  = $clog2(MAX_IN);
  localparam int DW     = PARALLEL*8;

  localparam logic [LEN_W-1:0] L_MAX = LEN_W'(MAX_IN);
  localparam logic [GRP_W-1:0] G_MAX = GRP_W'(MAX_GROUPS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_COMP  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [GRP_W-1:0]  grp_q, grp_d;
  logic [GIDX_W-1:0] g_q, g_d;
  logic [LEN_W-1:0]  k_q, k_d;
  logic [LEN_W-1:0]  wp_q, wp_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              drn_q, drn_d;
  logic [DW-1:0]     odata_q, odata_d;
  logic [GIDX_W-1:0] ogrp_q, ogrp_d;
  logic              done_q, done_d;
  logic              pres_q, first_q;
  logic [7:0]        rd_q;
  logic [ADDR_W-1:0] cur_addr;
  logic              last_grp;

  // Activation buffer is deliberately left out of reset so an abort keeps its contents.
  logic [7:0] abuf [MAX_IN];

  assign cur_addr = base_q + ADDR_W'(k_q);
  assign last_grp = (GRP_W'(g_q) == (grp_q - GRP_W'(1)));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    grp_d   = grp_q;
    g_d     = g_q;
    k_d     = k_q;
    wp_d    = wp_q;
    base_d  = base_q;
    waddr_d = waddr_q;
    drn_d   = drn_q;
    odata_d = odata_q;
    ogrp_d  = ogrp_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_start_i) begin
          if (cfg_in_len_i == '0 || cfg_num_groups_i == '0) begin
            done_d = 1'b1;
          end else begin
            len_d   = (cfg_in_len_i > L_MAX) ? L_MAX : cfg_in_len_i;
            grp_d   = (cfg_num_groups_i > G_MAX) ? G_MAX : cfg_num_groups_i;
            g_d     = '0;
            k_d     = '0;
            wp_d    = '0;
            base_d  = '0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (in_valid_i) begin
          wp_d = wp_q + LEN_W'(1);
          if (wp_q + LEN_W'(1) == len_q) begin
            k_d     = '0;
            state_d = S_COMP;
          end
        end
      end
      S_COMP: begin
        waddr_d = cur_addr;
        if (k_q == len_q - LEN_W'(1)) begin
          drn_d   = 1'b0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + LEN_W'(1);
        end
      end
      S_DRAIN: begin
        // Second drain cycle: last product has landed in the array accumulators.
        if (drn_q) begin
          odata_d = pe_out_i;
          ogrp_d  = g_q;
          state_d = S_OUT;
        end else begin
          drn_d = 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          if (last_grp) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            g_d     = g_q + GIDX_W'(1);
            base_d  = base_q + ADDR_W'(len_q);
            k_d     = '0;
            state_d = S_COMP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      grp_q   <= '0;
      g_q     <= '0;
      k_q     <= '0;
      wp_q    <= '0;
      base_q  <= '0;
      waddr_q <= '0;
      drn_q   <= 1'b0;
      odata_q <= '0;
      ogrp_q  <= '0;
      done_q  <= 1'b0;
      pres_q  <= 1'b0;
      first_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      grp_q   <= grp_d;
      g_q     <= g_d;
      k_q     <= k_d;
      wp_q    <= wp_d;
      base_q  <= base_d;
      waddr_q <= waddr_d;
      drn_q   <= drn_d;
      odata_q <= odata_d;
      ogrp_q  <= ogrp_d;
      done_q  <= done_d;
      pres_q  <= (state_q == S_COMP);
      first_q <= (state_q == S_COMP) && (k_q == '0);
      rd_q    <= abuf[k_q[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && in_valid_i) abuf[wp_q[IDX_W-1:0]] <= in_data_i;
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign in_ready_o  = (state_q == S_LOAD);
  assign w_ren_o     = (state_q == S_COMP);
  assign w_addr_o    = (state_q == S_COMP) ? cur_addr : waddr_q;
  assign pe_input_o  = pres_q ? rd_q : 8'd0;
  assign pe_w_o      = w_rdata_i;
  assign pe_clr_n_o  = ~first_q;
  assign out_valid_o = (state_q == S_OUT);
  assign out_data_o  = odata_q;
  assign out_group_o = ogrp_q;

endmodule

// File: tb/tb_fp_fcl_sched.sv
// Directed bench for fp_fcl_sched with weight-SRAM and PE-array models and a result scoreboard.
module tb_fp_fcl_sched;
  localparam int P  = 8;
  localparam int AW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cfg_start_i, busy_o, done_o, in_valid_i, in_ready_o;
  logic [8:0]    cfg_in_len_i;
  logic [6:0]    cfg_num_groups_i;
  logic [7:0]    in_data_i, pe_input_o;
  logic          w_ren_o, pe_clr_n_o, out_valid_o, out_ready_i;
  logic [AW-1:0] w_addr_o;
  logic [63:0]   w_rdata_i, pe_w_o, pe_out_i, out_data_o;
  logic [5:0]    out_group_o;

  fp_fcl_sched #(.PARALLEL(P), .MAX_IN(256), .MAX_GROUPS(64), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cfg_start_i(cfg_start_i), .cfg_in_len_i(cfg_in_len_i),
    .cfg_num_groups_i(cfg_num_groups_i), .busy_o(busy_o), .done_o(done_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .w_ren_o(w_ren_o), .w_addr_o(w_addr_o), .w_rdata_i(w_rdata_i),
    .pe_input_o(pe_input_o), .pe_w_o(pe_w_o), .pe_clr_n_o(pe_clr_n_o),
    .pe_out_i(pe_out_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_group_o(out_group_o));

  logic [63:0] wmem [0:1023];
  logic [7:0]  act  [0:255];

  function automatic logic [7:0] mul8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = a * b;
    return p[7:0];
  endfunction

  // Weight SRAM: one-cycle read latency.
  always @(posedge clk) if (w_ren_o) w_rdata_i <= wmem[w_addr_o[9:0]];

  // PE array: clr_n low loads the product, otherwise accumulates.
  always @(posedge clk)
    for (int j = 0; j < P; j++)
      pe_out_i[j*8 +: 8] <= pe_clr_n_o ? pe_out_i[j*8 +: 8] + mul8(pe_input_o, pe_w_o[j*8 +: 8])
                                       : mul8(pe_input_o, pe_w_o[j*8 +: 8]);

  function automatic logic [63:0] expv(input int L, input int g);
    logic [63:0] r;
    logic [7:0]  s;
    r = '0;
    for (int j = 0; j < P; j++) begin
      s = 8'd0;
      for (int k = 0; k < L; k++) s = s + mul8(act[k], wmem[g*L+k][j*8 +: 8]);
      r[j*8 +: 8] = s;
    end
    return r;
  endfunction

  typedef struct { logic [63:0] d; logic [5:0] g; } exp_t;
  exp_t sb[$];

  int tests = 0, fails = 0;
  int cyc_n = 0, stall_left = 0, beats = 0, cur_L = 0, cur_G = 0;
  int clr_cnt = 0, done_cnt = 0, exp_issue = -1;
  bit prev_wren = 0, have_hold = 0;
  logic [63:0] hold_d;
  logic [5:0]  hold_g;
  int addr_log[$], wcyc_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor at the falling edge, return just after the rising edge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    cyc_n++;
    if (stall_left > 0 && out_valid_o) begin
      out_ready_i = 1'b0;
      if (!have_hold) begin
        hold_d = out_data_o; hold_g = out_group_o; have_hold = 1;
      end else begin
        chk("stall_data", out_data_o, hold_d);
        chk("stall_group", {58'd0, out_group_o}, {58'd0, hold_g});
      end
      chk("stall_no_wren", {63'd0, w_ren_o}, 64'd0);
      stall_left--;
    end else begin
      out_ready_i = 1'b1;
    end
    if (w_ren_o) begin
      addr_log.push_back(int'(w_addr_o));
      wcyc_log.push_back(cyc_n);
      if (!prev_wren) chk("issue_start", cyc_n, exp_issue);
    end
    prev_wren = w_ren_o;
    if (!pe_clr_n_o) clr_cnt++;
    if (done_o) done_cnt++;
    if (in_valid_i && in_ready_o) begin
      beats++;
      if (beats == cur_L) exp_issue = cyc_n + 1;
    end
    if (out_valid_o && out_ready_i) begin
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("out_data", out_data_o, e.d);
        chk("out_group", {58'd0, out_group_o}, {58'd0, e.g});
        if (int'(e.g) != cur_G - 1) exp_issue = cyc_n + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_busy"}, {63'd0, busy_o}, 64'd0);
    chk({p, "_done"}, {63'd0, done_o}, 64'd0);
    chk({p, "_in_ready"}, {63'd0, in_ready_o}, 64'd0);
    chk({p, "_w_ren"}, {63'd0, w_ren_o}, 64'd0);
    chk({p, "_out_valid"}, {63'd0, out_valid_o}, 64'd0);
    chk({p, "_clr_n"}, {63'd0, pe_clr_n_o}, 64'd1);
    chk({p, "_pe_input"}, {56'd0, pe_input_o}, 64'd0);
    chk({p, "_w_addr"}, {50'd0, w_addr_o}, 64'd0);
    chk({p, "_out_data"}, out_data_o, 64'd0);
    chk({p, "_out_group"}, {58'd0, out_group_o}, 64'd0);
  endtask

  task automatic run(input int L, input int G, input bit toggle, input bit poke, input int stall);
    int d0, n;
    bit ph, poked;
    beats = 0; cur_L = L; cur_G = G; clr_cnt = 0; d0 = done_cnt;
    addr_log.delete(); wcyc_log.delete();
    for (int g = 0; g < G; g++) sb.push_back('{expv(L, g), 6'(g)});
    cfg_start_i = 1; cfg_in_len_i = 9'(L); cfg_num_groups_i = 7'(G);
    cyc();
    cfg_start_i = 0;
    stall_left = stall; have_hold = 0;
    n = 0; ph = 0; poked = 0;
    while (done_cnt == d0 && n < 3000) begin
      in_valid_i = (beats < L) && (!toggle || !ph);
      in_data_i  = act[beats < L ? beats : 0];
      ph = ~ph;
      cfg_start_i = poke && prev_wren && !poked;
      if (cfg_start_i) begin
        poked = 1; cfg_in_len_i = 9'd5; cfg_num_groups_i = 7'd1;
      end
      cyc();
      n++;
    end
    in_valid_i = 0; cfg_start_i = 0;
    chk("done_seen", done_cnt - d0, 1);
    chk("sb_drained", sb.size(), 0);
    cyc();
    chk("end_busy", {63'd0, busy_o}, 64'd0);
    chk("done_single", {63'd0, done_o}, 64'd0);
  endtask

  initial begin
    int n;
    rst = 0; cfg_start_i = 0; cfg_in_len_i = '0; cfg_num_groups_i = '0;
    in_valid_i = 0; in_data_i = '0; out_ready_i = 1;
    for (int i = 0; i < 1024; i++) wmem[i] = '0;
    for (int i = 0; i < 256; i++) act[i] = '0;
    repeat (3) cyc();
    chk_reset("rst0");
    rst = 1;
    cyc();

    // L=3, G=1: all-ones weights, activations 1,2,3 -> 6 per lane.
    act[0] = 8'd1; act[1] = 8'd2; act[2] = 8'd3;
    for (int i = 0; i < 3; i++) wmem[i] = {8{8'd1}};
    run(3, 1, 0, 0, 0);
    chk("t1_addr_n", addr_log.size(), 3);
    for (int i = 0; i < addr_log.size(); i++) chk("t1_addr", addr_log[i], i);
    if (wcyc_log.size() == 3) chk("t1_consec", wcyc_log[2] - wcyc_log[0], 2);
    chk("t1_clr_once", clr_cnt, 1);

    // L=2, G=3: activations {2,-1}, group g weights {g+1,1} -> 1,3,5.
    act[0] = 8'd2; act[1] = 8'hFF;
    for (int g = 0; g < 3; g++) begin
      wmem[2*g]   = {8{8'(g + 1)}};
      wmem[2*g+1] = {8{8'd1}};
    end
    run(2, 3, 0, 0, 0);
    chk("t2_addr_n", addr_log.size(), 6);
    for (int i = 0; i < addr_log.size(); i++) chk("t2_addr", addr_log[i], i);
    chk("t2_clr", clr_cnt, 3);

    // Backpressure: L=4, G=2, 10 stalled cycles on the first result.
    for (int i = 0; i < 4; i++) act[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) wmem[i] = {$urandom, $urandom};
    run(4, 2, 0, 0, 10);
    chk("t3_addr_n", addr_log.size(), 8);

    // Gapped activation stream with L=4.
    for (int i = 0; i < 4; i++) act[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) wmem[i] = {$urandom, $urandom};
    run(4, 1, 1, 0, 0);
    chk("t4_beats", beats, 4);

    // L=0: no load, done the next cycle.
    cfg_start_i = 1; cfg_in_len_i = 9'd0; cfg_num_groups_i = 7'd1;
    cyc();
    cfg_start_i = 0;
    chk("l0_done", {63'd0, done_o}, 64'd1);
    chk("l0_in_ready", {63'd0, in_ready_o}, 64'd0);
    chk("l0_busy", {63'd0, busy_o}, 64'd0);
    cyc();
    chk("l0_done_clr", {63'd0, done_o}, 64'd0);

    // cfg_start issued while computing must be ignored.
    for (int i = 0; i < 3; i++) act[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) wmem[i] = {$urandom, $urandom};
    run(3, 2, 0, 1, 0);
    chk("poke_addr_n", addr_log.size(), 6);

    // Reset during COMPUTE at k=1, then a clean run.
    for (int i = 0; i < 4; i++) act[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) wmem[i] = {$urandom, $urandom};
    beats = 0; cur_L = 4; cur_G = 1;
    cfg_start_i = 1; cfg_in_len_i = 9'd4; cfg_num_groups_i = 7'd1;
    cyc();
    cfg_start_i = 0;
    n = 0;
    while (!prev_wren && n < 200) begin
      in_valid_i = (beats < 4);
      in_data_i  = act[beats < 4 ? beats : 0];
      cyc();
      n++;
    end
    in_valid_i = 0;
    chk("rst_reach_comp", {63'd0, prev_wren}, 64'd1);
    rst = 0;
    cyc();
    chk_reset("rst_mid");
    rst = 1;
    sb.delete();
    cyc();
    run(4, 2, 0, 0, 0);
    chk("rst_fresh_addr_n", addr_log.size(), 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_fcl_sched.md
Name: fp_fcl_sched

Overview:
- Upstream sequencer for the fixed-point fully-connected PE array (FP_PARALLEL 8-bit MAC lanes sharing one activation per cycle).
- Buffers one input activation vector, then for each output group streams activation k and weight word k into the array, framing each dot product with an active-low accumulator-clear strobe.
- After each dot product it captures the array result and presents it on a valid/ready output stream.
- Sits between the activation stream and the weight SRAM on one side, and the PE array on the other.

Parameters:
- PARALLEL, 8, lanes per group; equals FP_PARALLEL of the array.
- MAX_IN, 256, maximum input vector length (activation buffer depth).
- MAX_GROUPS, 64, maximum output groups per run.
- ADDR_W, 14, weight memory address width; must be >= clog2(MAX_IN*MAX_GROUPS).

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset.
- cfg_start, input, 1, single-cycle run request; sampled only in IDLE.
- cfg_in_len, input, clog2(MAX_IN+1), input vector length L.
- cfg_num_groups, input, clog2(MAX_GROUPS+1), number of output groups G.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when a run completes.
- in_valid, input, 1, activation stream valid.
- in_ready, output, 1, activation stream ready.
- in_data, input, 8, signed activation.
- w_ren, output, 1, weight read enable.
- w_addr, output, ADDR_W, weight word address.
- w_rdata, input, PARALLEL*8, weight word; valid exactly 1 cycle after w_ren.
- pe_input, output, 8, activation to the array.
- pe_w, output, PARALLEL*8, weights to the array (w_rdata passed straight through).
- pe_clr_n, output, 1, array accumulator clear/load-first-product, active-low.
- pe_out, input, PARALLEL*8, array accumulators.
- out_valid, output, 1, result valid.
- out_ready, input, 1, result ready.
- out_data, output, PARALLEL*8, captured group result.
- out_group, output, clog2(MAX_GROUPS), index of the presented group.

Behaviour:
- Reset: rst, synchronous, active-low; clock clk.
- Reset values: state=IDLE; in_ready, w_ren, out_valid, busy, done = 0; pe_clr_n = 1; pe_input = 0; w_addr, out_data, out_group = 0.
- Reset effect: rst low at any time aborts the run; the activation buffer contents are not cleared.
- All handshakes complete when valid && ready at a rising edge.
- IDLE:
  - cfg_start with L=0 or G=0: no load; done pulses the next cycle; stay IDLE.
  - Otherwise: latch L and G, set g=0, go LOAD.
  - L>MAX_IN or G>MAX_GROUPS is a caller error; the block clamps both to their maximums.
- LOAD:
  - in_ready=1.
  - Each accepted beat writes buf[wp] and increments wp.
  - On the L-th accepted beat, go COMPUTE the next cycle.
- COMPUTE (entered at cycle T):
  - Cycles T..T+L-1: w_ren=1, w_addr = g*L + k for k=0..L-1; synchronous buffer read of buf[k] in the same cycle.
  - Cycle T+1+k: pe_input = buf[k], pe_w = w_rdata.
  - pe_clr_n=0 only in cycle T+1 (the k=0 presentation), so the array loads the first product rather than accumulating.
  - After the last issue, go DRAIN.
- Outside presentation cycles:
  - pe_input=0 and pe_clr_n=1, so the array holds its value (adds 0).
  - w_ren=0 and w_addr holds its last value.
- DRAIN: two cycles (T+L, T+L+1). At the end of T+L+1, capture pe_out into out_data and g into out_group; go OUT.
- OUT:
  - out_valid=1 from cycle T+L+2; out_data and out_group stay stable until the handshake.
  - On handshake, if g==G-1: go IDLE and pulse done in the next cycle.
  - Otherwise: g++ and enter COMPUTE in the next cycle.
  - out_ready held low stalls the block indefinitely; the array is not driven during the stall.
- Per-group latency: L+2 cycles from COMPUTE entry to out_valid. Minimum group period: L+3 cycles.
- cfg_start while busy is ignored.
- in_valid outside LOAD is ignored (in_ready=0).
- Arithmetic: no arithmetic on data; pure data movement. Address product g*L is computed in ADDR_W bits with no wrap for legal configurations.

Test Plan:
- L=3, G=1, activations {1,2,3}, weight word all lanes {1,1,1} at addr 0..2 -> w_addr 0,1,2 in consecutive cycles; pe_clr_n low exactly once; out_data every lane = 6, out_group=0, then done pulse.
- L=2, G=3, activations {2,-1}, group g lanes weights {g+1, 1} -> w_addr sequence 0,1,2,3,4,5; results per lane 1, 3, 5 on groups 0, 1, 2 in order.
- Backpressure: L=4, G=2, out_ready low for 10 cycles after first out_valid -> out_data/out_group stable; no w_ren during stall; second group starts the cycle after the handshake.
- in_valid toggling 1,0,1,0 during LOAD with L=4 -> exactly 4 beats written; COMPUTE begins the cycle after the 4th accepted beat; results match an ideal stream.
- cfg_start with L=0 -> no in_ready, done pulses next cycle; cfg_start during COMPUTE -> ignored, run unaffected.
- rst low in mid-COMPUTE (k=1 of L=4) -> next cycle IDLE with all outputs at reset values; a fresh run afterwards produces correct results.
